// File: rtl/game_set_if.sv
// Board geometry bundle shared by the Saper game stages.
// Carries the board origin, cell pitch and cells-per-side for the current level.
interface game_set_if;
  logic [10:0] board_xpos;
  logic [10:0] board_ypos;
  logic [5:0]  button_size;
  logic [4:0]  button_num;

  modport master (
    output board_xpos, board_ypos,
    output button_size, button_num
  );

  modport slave (
    input board_xpos, board_ypos,
    input button_size, button_num
  );

  modport out (
    output board_xpos, board_ypos,
    output button_size, button_num
  );

  modport in (
    input board_xpos, board_ypos,
    input button_size, button_num
  );
endinterface

// File: rtl/flag_ctl.sv
// Right-click flag controller: mouse position -> cell by repeated subtraction,
// then toggles the cell flag and tracks the flag count. Option: FLAG_LIMIT_EN.
module flag_ctl #(
  parameter int CTR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        level,
  game_set_if.in            gin,
  input  logic [11:0]       mouse_xpos,
  input  logic [11:0]       mouse_ypos,
  input  logic              right,
  input  logic              game_reset,
  input  logic [CTR_W-1:0]  max_flags,
  output logic [7:0][7:0]   defuse_arr_easy,
  output logic [9:0][9:0]   defuse_arr_medium,
  output logic [15:0][15:0] defuse_arr_hard,
  output logic [CTR_W-1:0]  flag_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    UPDATE
  } state_t;

  localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

  state_t      state;
  state_t      nxt;
  logic        right_d;
  logic [1:0]  level_q;
  logic [11:0] rel_x;
  logic [11:0] rel_y;
  logic [4:0]  col;
  logic [4:0]  row;

  logic        click;
  logic        clear;
  logic        in_board;
  logic        start;
  logic [11:0] bx;
  logic [11:0] by;
  logic [11:0] sz;
  logic        x_step;
  logic        y_step;

  logic        cell_ok;
  logic        cur_bit;
  logic        set_ok;
  logic        do_set;
  logic        do_clr;
  logic        cnt_inc;
  logic        cnt_dec;

  assign bx = {1'b0, gin.board_xpos};
  assign by = {1'b0, gin.board_ypos};
  assign sz = {6'd0, gin.button_size};

  assign click = right & ~right_d;
  assign clear = game_reset | (level != level_q);

  assign in_board = (level != 2'd0) &&
                    (mouse_xpos >= bx) &&
                    (mouse_ypos >= by);

  assign start = (state == IDLE) && click &&
                 in_board && !clear;

  assign x_step = (state == DIV_X) &&
                  (col != gin.button_num) &&
                  (rel_x >= sz);

  assign y_step = (state == DIV_Y) &&
                  (row != gin.button_num) &&
                  (rel_y >= sz);

  // Edge detector and level copy used for change-of-level clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      right_d <= 1'b0;
      level_q <= 2'd0;
    end else begin
      right_d <= right;
      level_q <= level;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; a clear always wins and returns to IDLE.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = DIV_X;
      end
      DIV_X: begin
        if (col == gin.button_num) nxt = IDLE;
        else if (rel_x < sz)       nxt = DIV_Y;
      end
      DIV_Y: begin
        if (row == gin.button_num) nxt = IDLE;
        else if (rel_y < sz)       nxt = UPDATE;
      end
      UPDATE: begin
        nxt = IDLE;
      end
    endcase
    if (clear) nxt = IDLE;
  end

  // busy mirrors "not IDLE", registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (nxt != IDLE);
  end

  // Division datapath: latch offsets on a click, then subtract the pitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rel_x <= '0;
      rel_y <= '0;
      col   <= '0;
      row   <= '0;
    end else if (start) begin
      rel_x <= mouse_xpos - bx;
      rel_y <= mouse_ypos - by;
      col   <= '0;
      row   <= '0;
    end else begin
      if (x_step) begin
        rel_x <= rel_x - sz;
        col   <= col + 5'd1;
      end
      if (y_step) begin
        rel_y <= rel_y - sz;
        row   <= row + 5'd1;
      end
    end
  end

  // Look up the addressed bit; cells outside the level's array never match.
  always_comb begin
    cell_ok = 1'b0;
    cur_bit = 1'b0;
    case (level)
      2'd1: begin
        if (col < 5'd8 && row < 5'd8) begin
          cell_ok = 1'b1;
          cur_bit = defuse_arr_easy[col[2:0]][row[2:0]];
        end
      end
      2'd2: begin
        if (col < 5'd10 && row < 5'd10) begin
          cell_ok = 1'b1;
          cur_bit = defuse_arr_medium[col[3:0]][row[3:0]];
        end
      end
      2'd3: begin
        if (col < 5'd16 && row < 5'd16) begin
          cell_ok = 1'b1;
          cur_bit = defuse_arr_hard[col[3:0]][row[3:0]];
        end
      end
      default: begin
        cell_ok = 1'b0;
        cur_bit = 1'b0;
      end
    endcase
  end

`ifdef FLAG_LIMIT_EN
  assign set_ok  = (flag_count < max_flags);
  assign cnt_inc = do_set;
`else
  logic unused_max;
  assign unused_max = ^max_flags;
  assign set_ok     = 1'b1;
  assign cnt_inc    = do_set && (flag_count != '1);
`endif

  assign do_clr  = (state == UPDATE) && !clear &&
                   cell_ok && cur_bit;
  assign do_set  = (state == UPDATE) && !clear &&
                   cell_ok && !cur_bit && set_ok;
  assign cnt_dec = do_clr && (flag_count != '0);

  // Flag arrays: cleared on a new game or level change, else toggled.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      defuse_arr_easy   <= '0;
      defuse_arr_medium <= '0;
      defuse_arr_hard   <= '0;
    end else if (do_set || do_clr) begin
      case (level)
        2'd1: defuse_arr_easy[col[2:0]][row[2:0]]   <= do_set;
        2'd2: defuse_arr_medium[col[3:0]][row[3:0]] <= do_set;
        2'd3: defuse_arr_hard[col[3:0]][row[3:0]]   <= do_set;
        default: ;
      endcase
    end
  end

  // Flag counter follows the toggles and never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear)  flag_count <= '0;
    else if (cnt_dec)  flag_count <= flag_count - ONE;
    else if (cnt_inc)  flag_count <= flag_count + ONE;
  end

endmodule

// File: tb/tb_flag_ctl.sv
// Self-checking bench for flag_ctl: table of clicks with a scoreboard queue
// plus hand-written sequences for abort, level change and held buttons.
module tb_flag_ctl;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        level;
  logic [11:0]       mouse_xpos;
  logic [11:0]       mouse_ypos;
  logic              right;
  logic              game_reset;
  logic [7:0]        max_flags;
  logic [7:0][7:0]   defuse_arr_easy;
  logic [9:0][9:0]   defuse_arr_medium;
  logic [15:0][15:0] defuse_arr_hard;
  logic [7:0]        flag_count;
  logic              busy;

  game_set_if gs();

  flag_ctl #(.CTR_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .level             (level),
    .gin               (gs),
    .mouse_xpos        (mouse_xpos),
    .mouse_ypos        (mouse_ypos),
    .right             (right),
    .game_reset        (game_reset),
    .max_flags         (max_flags),
    .defuse_arr_easy   (defuse_arr_easy),
    .defuse_arr_medium (defuse_arr_medium),
    .defuse_arr_hard   (defuse_arr_hard),
    .flag_count        (flag_count),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int ecol;
    int erow;
    int ebit;
    int ecnt;
    int ebusy;
    int elat;
  } vec_t;

  vec_t tbl [7];
  vec_t sb [$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input longint got,
                       input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got %0d want %0d", name, got, exp);
  endtask

  // Click at (x,y); returns busy cycles and edges from E0 to count change.
  task automatic do_click(input int x, input int y,
                          output int bn, output int lat);
    int     chg;
    logic [7:0] prev;
    bit     done;
    @(negedge clk);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
    right = 1'b1;
    prev = flag_count;
    bn = 0;
    chg = -1;
    done = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (flag_count != prev && chg < 0) chg = i;
      if (busy) bn++;
      else begin
        done = 1;
        break;
      end
    end
    if (!done) check("busy_timeout", 1, 0);
    lat = chg - 1;
    right = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v);
    int   bn;
    int   lat;
    vec_t e;
    sb.push_back(v);
    do_click(v.x, v.y, bn, lat);
    e = sb.pop_front();
    if (e.ecol >= 0)
      check("cell_bit", defuse_arr_easy[e.ecol][e.erow], e.ebit);
    check("flag_count", flag_count, e.ecnt);
    if (e.ebusy >= 0) check("busy_cycles", bn, e.ebusy);
    if (e.elat >= 0) check("latency", lat, e.elat);
  endtask

  initial begin
    int   bn;
    int   lat;
    vec_t v;

    tbl = '{
      '{145,  95,  2,  2, 1, 1,  7,  7},
      '{145,  95,  2,  2, 0, 0,  7,  7},
      '{ 99,  60, -1, -1, 0, 0,  0, -1},
      '{300,  60, -1, -1, 0, 0,  9, -1},
      '{101,  51,  0,  0, 1, 1,  3,  3},
      '{259, 209,  7,  7, 1, 2, 17, 17},
      '{100, 210, -1, -1, 0, 2, 10, -1}
    };

    rst = 1'b1;
    level = 2'd1;
    mouse_xpos = '0;
    mouse_ypos = '0;
    right = 1'b0;
    game_reset = 1'b0;
    max_flags = 8'd10;
    gs.board_xpos = 11'd100;
    gs.board_ypos = 11'd50;
    gs.button_size = 6'd20;
    gs.button_num = 5'd8;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_count", flag_count, 0);
    check("reset_busy", busy, 0);
    check("reset_easy", $countones(defuse_arr_easy), 0);
    check("reset_medium", $countones(defuse_arr_medium), 0);
    check("reset_hard", $countones(defuse_arr_hard), 0);

    for (int i = 0; i < 7; i++) apply_vec(tbl[i]);
    check("medium_idle", $countones(defuse_arr_medium), 0);
    check("hard_idle", $countones(defuse_arr_hard), 0);

    // new game clears everything
    @(negedge clk);
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    @(negedge clk);
    check("game_reset_count", flag_count, 0);
    check("game_reset_easy", $countones(defuse_arr_easy), 0);

    // flag limit: 11 distinct cells
    for (int i = 0; i < 11; i++) begin
      v.x = 105 + 20 * (i % 8);
      v.y = 55 + 20 * (i / 8);
      v.ecol = i % 8;
      v.erow = i / 8;
      v.ebusy = (i % 8) + (i / 8) + 3;
      v.elat = -1;
`ifdef FLAG_LIMIT_EN
      v.ebit = (i < 10) ? 1 : 0;
      v.ecnt = (i < 10) ? i + 1 : 10;
`else
      v.ebit = 1;
      v.ecnt = i + 1;
`endif
      apply_vec(v);
    end
`ifdef FLAG_LIMIT_EN
    check("limit_bits", $countones(defuse_arr_easy), 10);
`else
    check("limit_bits", $countones(defuse_arr_easy), 11);
`endif

    // abort: game_reset two cycles after the click edge
    @(negedge clk);
    mouse_xpos = 12'd255;
    mouse_ypos = 12'd205;
    right = 1'b1;
    @(negedge clk);
    check("abort_busy_start", busy, 1);
    @(negedge clk);
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    right = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_count", flag_count, 0);
    check("abort_easy", $countones(defuse_arr_easy), 0);
    repeat (30) @(negedge clk);
    check("abort_after_count", flag_count, 0);
    check("abort_after_easy", $countones(defuse_arr_easy), 0);

    // level change 1 -> 2 clears, then medium geometry works
    do_click(145, 95, bn, lat);
    check("pre_level_bit", defuse_arr_easy[2][2], 1);
    level = 2'd2;
    gs.button_num = 5'd10;
    @(negedge clk);
    check("level_chg_count", flag_count, 0);
    check("level_chg_easy", $countones(defuse_arr_easy), 0);
    do_click(285, 95, bn, lat);
    check("medium_bit", defuse_arr_medium[9][2], 1);
    check("medium_count", flag_count, 1);
    check("medium_easy", $countones(defuse_arr_easy), 0);
    level = 2'd1;
    gs.button_num = 5'd8;
    @(negedge clk);
    check("level_back_medium", $countones(defuse_arr_medium), 0);

    // held right button for 50 cycles toggles once
    @(negedge clk);
    mouse_xpos = 12'd145;
    mouse_ypos = 12'd95;
    right = 1'b1;
    repeat (50) @(negedge clk);
    right = 1'b0;
    @(negedge clk);
    check("held_count", flag_count, 1);
    check("held_bit", defuse_arr_easy[2][2], 1);

    // second edge while busy is dropped
    right = 1'b1;
    @(negedge clk);
    @(negedge clk);
    right = 1'b0;
    @(negedge clk);
    right = 1'b1;
    repeat (30) @(negedge clk);
    right = 1'b0;
    @(negedge clk);
    check("busy_edge_count", flag_count, 0);
    check("busy_edge_bit", defuse_arr_easy[2][2], 0);

    // level 0: no game, clicks ignored
    level = 2'd0;
    @(negedge clk);
    do_click(145, 95, bn, lat);
    check("lvl0_busy", bn, 0);
    check("lvl0_count", flag_count, 0);
    check("lvl0_easy", $countones(defuse_arr_easy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
